// File: rtl/aibcr3aux_osc_rdy_cnt_if.sv
// Control/status bundle of the oscillator-ready counter: enable and settle
// select toward the block, ready / downstream reset / heartbeat tick back out.
`timescale 1ns/1ps

interface aibcr3aux_osc_rdy_cnt_if;
  logic       en;
  logic [1:0] cnt_sel;
  logic       osc_rdy;
  logic       rdy_rstb;
  logic       tick;
  logic [1:0] cnt_state;

  modport master (
    output en,
    output cnt_sel,
    input  osc_rdy,
    input  rdy_rstb,
    input  tick,
    input  cnt_state
  );

  modport slave (
    input  en,
    input  cnt_sel,
    output osc_rdy,
    output rdy_rstb,
    output tick,
    output cnt_state
  );
endinterface

// File: rtl/aibcr3aux_osc_rdy_cnt.sv
// Oscillator settle counter: after a selectable number of divided-clock cycles
// it declares the oscillator ready, releases a downstream reset and emits a
// heartbeat tick every 64 cycles.
`timescale 1ns/1ps

module aibcr3aux_osc_rdy_cnt #(
  parameter int CNT_W = 14
) (
  input  logic                      clkin,
  input  logic                      por,
  inout  wire                       vcc_aibcr3aux,
  inout  wire                       vss_aibcr3aux,
  aibcr3aux_osc_rdy_cnt_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    COUNT = 2'b01,
    READY = 2'b10
  } state_e;

  // Supply pins exist for netlist connectivity only.
  wire supply_unused = vcc_aibcr3aux ^ vss_aibcr3aux;

  logic [1:0]       rst_sync;
  logic             rst_s;
  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_last;
  logic [1:0]       sel_q;
  logic [5:0]       tick_cnt;
  logic             osc_rdy_q;
  logic             rdy_rstb_q;
  logic             tick_q;

  // NOTE: por asserts asynchronously, but its release is retimed through two
  // flops so every state flop leaves reset on the same clkin edge.
  always_ff @(posedge clkin or negedge por) begin
    if (!por) rst_sync <= 2'b00;
    else      rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_s = rst_sync[1];

  // NOTE: every branch assigns a default first so no latch can be inferred.
  always_comb begin
    cnt_last = '0;
    case (sel_q)
      2'b00:   cnt_last = CNT_W'(255);
      2'b01:   cnt_last = CNT_W'(1023);
      2'b10:   cnt_last = CNT_W'(4095);
      default: cnt_last = CNT_W'(16383);
    endcase
  end

  // NOTE: all state updates use non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clkin or negedge por) begin
    if (!por) begin
      state      <= IDLE;
      cnt        <= '0;
      sel_q      <= 2'b00;
      tick_cnt   <= '0;
      osc_rdy_q  <= 1'b0;
      rdy_rstb_q <= 1'b0;
      tick_q     <= 1'b0;
    end else if (!rst_s) begin
      state      <= IDLE;
      cnt        <= '0;
      sel_q      <= 2'b00;
      tick_cnt   <= '0;
      osc_rdy_q  <= 1'b0;
      rdy_rstb_q <= 1'b0;
      tick_q     <= 1'b0;
    end else if (!bus.en) begin
      // Dropping enable abandons any partial count; sel_q is re-latched later.
      state      <= IDLE;
      cnt        <= '0;
      tick_cnt   <= '0;
      osc_rdy_q  <= 1'b0;
      rdy_rstb_q <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state <= COUNT;
          cnt   <= '0;
          sel_q <= bus.cnt_sel;
        end
        COUNT: begin
          if (cnt == cnt_last) begin
            state      <= READY;
            tick_cnt   <= '0;
            osc_rdy_q  <= 1'b1;
            rdy_rstb_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        READY: begin
          // Settle counter stays frozen; the 6-bit tick counter wraps by itself.
          tick_cnt <= tick_cnt + 1'b1;
          tick_q   <= (tick_cnt == 6'd63);
        end
        default: begin
          state      <= IDLE;
          cnt        <= '0;
          tick_cnt   <= '0;
          osc_rdy_q  <= 1'b0;
          rdy_rstb_q <= 1'b0;
          tick_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.osc_rdy   = osc_rdy_q;
  assign bus.rdy_rstb  = rdy_rstb_q;
  assign bus.tick      = tick_q;
  assign bus.cnt_state = state;

endmodule

// File: tb/tb_aibcr3aux_osc_rdy_cnt.sv
// Directed bench for the oscillator-ready counter: reset, settle lengths,
// tick cadence, enable drop, async por pulse and a stalled clock.
`timescale 1ns/1ps

module tb_aibcr3aux_osc_rdy_cnt;

  logic clkin;
  logic por;
  logic clk_run;
  wire  vcc = 1'b1;
  wire  vss = 1'b0;
  int   vectors;
  int   miscompares;

  aibcr3aux_osc_rdy_cnt_if bus ();

  aibcr3aux_osc_rdy_cnt #(.CNT_W(14)) dut (
    .clkin         (clkin),
    .por           (por),
    .vcc_aibcr3aux (vcc),
    .vss_aibcr3aux (vss),
    .bus           (bus)
  );

  // A stop request lets the clock finish its high phase and park low.
  initial begin
    clkin = 1'b0;
    forever begin
      #5;
      if (clk_run || clkin) clkin = ~clkin;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clkin);
    #1;
  endtask

  task automatic release_por();
    por = 1'b1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    clk_run     = 1'b1;
    por         = 1'b0;
    bus.en      = 1'b1;
    bus.cnt_sel = 2'b00;

    // Reset state held while por is low.
    run(4);
    check("rst_osc_rdy",  {31'd0, bus.osc_rdy},   0);
    check("rst_rdy_rstb", {31'd0, bus.rdy_rstb},  0);
    check("rst_tick",     {31'd0, bus.tick},      0);
    check("rst_state",    {30'd0, bus.cnt_state}, 0);

    // cnt_sel=00: ready at edge 259 after release.
    release_por();
    run(2);
    check("s00_e2_state",   {30'd0, bus.cnt_state}, 0);
    run(1);
    check("s00_e3_state",   {30'd0, bus.cnt_state}, 1);
    check("s00_e3_tick",    {31'd0, bus.tick},      0);
    run(255);
    check("s00_e258_rdy",   {31'd0, bus.osc_rdy},   0);
    check("s00_e258_state", {30'd0, bus.cnt_state}, 1);
    run(1);
    check("s00_e259_rdy",   {31'd0, bus.osc_rdy},   1);
    check("s00_e259_rstb",  {31'd0, bus.rdy_rstb},  1);
    check("s00_e259_state", {30'd0, bus.cnt_state}, 2);

    // Tick cadence: high on edges 64, 128, 192, 256 after ready, else low.
    for (int k = 1; k <= 256; k++) begin
      run(1);
      check($sformatf("tick_k%0d", k), {31'd0, bus.tick}, (k % 64 == 0) ? 1 : 0);
    end
    check("ready_hold", {31'd0, bus.osc_rdy}, 1);

    // 1 ns por pulse between edges while tick is high clears outputs at once.
    #2 por = 1'b0;
    #0.5;
    check("por_pulse_rdy",   {31'd0, bus.osc_rdy},   0);
    check("por_pulse_rstb",  {31'd0, bus.rdy_rstb},  0);
    check("por_pulse_tick",  {31'd0, bus.tick},      0);
    check("por_pulse_state", {30'd0, bus.cnt_state}, 0);
    #0.5 por = 1'b1;
    run(258);
    check("repor_e258_rdy", {31'd0, bus.osc_rdy}, 0);
    run(1);
    check("repor_e259_rdy", {31'd0, bus.osc_rdy}, 1);

    // cnt_sel=11 with a mid-count change to 00 that must be ignored.
    por = 1'b0;
    bus.cnt_sel = 2'b11;
    run(2);
    release_por();
    run(100);
    bus.cnt_sel = 2'b00;
    run(16286);
    check("s11_e16386_rdy", {31'd0, bus.osc_rdy}, 0);
    run(1);
    check("s11_e16387_rdy", {31'd0, bus.osc_rdy}, 1);

    // cnt_sel=01 with the clock stalled during COUNT.
    por = 1'b0;
    bus.cnt_sel = 2'b01;
    run(2);
    release_por();
    run(203);
    check("stall_pre_state", {30'd0, bus.cnt_state}, 1);
    clk_run = 1'b0;
    #200;
    check("stall_state", {30'd0, bus.cnt_state}, 1);
    check("stall_rdy",   {31'd0, bus.osc_rdy},   0);
    clk_run = 1'b1;
    run(823);
    check("stall_e1026_rdy", {31'd0, bus.osc_rdy}, 0);
    run(1);
    check("stall_e1027_rdy", {31'd0, bus.osc_rdy}, 1);

    // en low in READY returns to IDLE and clears the outputs next edge.
    bus.en = 1'b0;
    run(1);
    check("en_off_state", {30'd0, bus.cnt_state}, 0);
    check("en_off_rdy",   {31'd0, bus.osc_rdy},   0);
    check("en_off_rstb",  {31'd0, bus.rdy_rstb},  0);
    check("en_off_tick",  {31'd0, bus.tick},      0);

    // en dropped at counter=500 then restored: full 1024 recount.
    bus.en = 1'b1;
    run(501);
    check("en_cnt500_state", {30'd0, bus.cnt_state}, 1);
    bus.en = 1'b0;
    run(1);
    check("en_drop_state", {30'd0, bus.cnt_state}, 0);
    bus.en = 1'b1;
    run(1024);
    check("en_ret_e1024_rdy", {31'd0, bus.osc_rdy}, 0);
    run(1);
    check("en_ret_e1025_rdy",   {31'd0, bus.osc_rdy},   1);
    check("en_ret_e1025_state", {30'd0, bus.cnt_state}, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/aibcr3aux_osc_rdy_cnt.md
AIBCR3AUX_OSC_RDY_CNT -- requirements
Module: aibcr3aux_osc_rdy_cnt

Interface
REQ-001 The block SHALL have the parameter CNT_W, default 14, meaning the width of the settle counter.
REQ-002 Port clkin  input  1  sole clock, driven by out_divby8 of the oscillator divider; all logic SHALL be rising-edge clocked.
REQ-003 Port por  input  1  asynchronous active-low reset; low SHALL reset all state immediately, regardless of clkin.
REQ-004 Port vcc_aibcr3aux  inout  1  supply, connectivity only.
REQ-005 Port vss_aibcr3aux  inout  1  ground, connectivity only.
REQ-006 Port en  input  1  counting enable, synchronous to clkin.
REQ-007 Port cnt_sel  input  2  settle-time select: 00=256, 01=1024, 10=4096, 11=16384 cycles.
REQ-008 Port osc_rdy  output  1  registered; high when the oscillator has settled.
REQ-009 Port rdy_rstb  output  1  registered active-low reset for downstream logic; equals osc_rdy.
REQ-010 Port tick  output  1  registered one-cycle pulse, every 64 clkin cycles while ready.
REQ-011 Port cnt_state  output  2  current FSM state encoding, for observation only.

Function
REQ-012 por SHALL be synchronised by a 2-flop chain (rst_s) to give asynchronous assertion and synchronous release; internal logic SHALL leave reset at the 2nd clkin rising edge after por rises.
REQ-013 The FSM SHALL have three states: IDLE=00, COUNT=01 and READY=10; encoding 11 is illegal and SHALL return to IDLE on the next edge.
REQ-014 IDLE with en=1 SHALL go to COUNT on the next edge, clear the counter to 0 and latch cnt_sel into sel_q.
REQ-015 COUNT SHALL increment the counter by 1 each edge; when counter==N-1 (N from sel_q) the next edge SHALL go to READY and set osc_rdy=1.
REQ-016 osc_rdy SHALL therefore rise exactly N edges after the edge that entered COUNT.
REQ-017 cnt_sel changes while in COUNT or READY SHALL have no effect until the next entry into COUNT.
REQ-018 en=0 in any state SHALL, on the next edge, go to IDLE, clear the counter and the tick counter, and drive osc_rdy=0 and tick=0.
REQ-019 READY SHALL hold osc_rdy=1 while en=1; the counter SHALL freeze and SHALL NOT wrap.
REQ-020 In READY, a 6-bit tick counter SHALL start at 0 on entry and increment each edge; tick SHALL be 1 for the edge after the counter reaches 63, then the counter SHALL wrap to 0.
REQ-021 The first tick SHALL occur 64 edges after osc_rdy rises, then every 64 edges.
REQ-022 tick SHALL NOT be asserted outside READY.
REQ-023 rdy_rstb SHALL be a separate flop with the same value as osc_rdy, with no combinational path to outputs.
REQ-024 cnt_state SHALL reflect the registered FSM state.

Reset
REQ-025 While por=0 or rst_s=0: state=IDLE, counter=0, sel_q=00, tick counter=0, osc_rdy=0, rdy_rstb=0, tick=0, cnt_state=00.
REQ-026 por falling mid-COUNT or in READY SHALL clear osc_rdy, rdy_rstb and tick asynchronously, with no need for a clkin edge.
REQ-027 After por release, the sequence SHALL restart from IDLE and SHALL never resume a partial count.

Verification
REQ-028 por 0->1 with en=1 and cnt_sel=00: osc_rdy and rdy_rstb rise at the 259th clkin rising edge after por rises (2 sync + 1 IDLE->COUNT + 256), and not earlier.
REQ-029 Same as REQ-028 but cnt_sel=11: osc_rdy rises at edge 16387; changing cnt_sel to 00 at edge 100 does not change this.
REQ-030 In READY for 200 edges: tick pulses exactly at edges 64, 128 and 192 after osc_rdy rises, each one cycle wide.
REQ-031 en dropped at COUNT counter=500 (cnt_sel=01), then restored: state goes to 00 next edge, and osc_rdy rises 1025 edges after en returns.
REQ-032 por pulsed low for 1 ns between clkin edges while in READY: osc_rdy, rdy_rstb and tick go 0 immediately; after release, full recount to edge 259 (cnt_sel=00).
REQ-033 Clock stopped during COUNT: state and counter hold, osc_rdy stays 0, and counting continues from the held value when clkin resumes.
